// File: rtl/node_iter_succ.sv
// node_iter_succ
// Successor node for the recursive-function tree. Computes RES = IN + CNT by
// applying the successor operation CNT times, one step per clock. This avoids
// a combinational adder chain. Wrap or saturate behaviour is chosen per
// operation, and overflow is reported through OVF.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RST   - synchronous active-low reset
//   ST    - start request, an operation launches on its rising edge while idle
//   IN    - base operand (W bits), captured at launch
//   CNT   - number of successor steps (CNT_W bits), captured at launch
//   MODE  - 0 = wrap modulo 2^W, 1 = saturate at 2^W-1, captured at launch
//   RD    - ready: 1 = idle with RES/OVF valid, 0 = busy
//   RES   - result of the last completed operation
//   OVF   - overflow flag of the last completed operation
module node_iter_succ #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [W-1:0]     IN,
  input  logic [CNT_W-1:0] CNT,
  input  logic             MODE,
  output logic             RD,
  output logic [W-1:0]     RES,
  output logic             OVF
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam logic [W-1:0] MAXV = '1;

  state_t           state, state_nxt;
  logic             st_q;
  logic [W-1:0]     acc, acc_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             mode_q, mode_nxt;
  logic             ovf_int, ovf_int_nxt;
  logic             rd_nxt;
  logic [W-1:0]     res_nxt;
  logic             ovf_nxt;
  logic             st_rise;

  // Only a 0->1 transition of ST counts. A start held high across completion
  // must not relaunch.
  assign st_rise = ST & ~st_q;

  // Next-state and datapath decisions. In RUN, one successor step is taken
  // per cycle until the remaining count reaches zero. The following cycle
  // publishes the accumulator, which gives the CNT+1 busy cycles.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    rem_nxt     = rem;
    mode_nxt    = mode_q;
    ovf_int_nxt = ovf_int;
    rd_nxt      = RD;
    res_nxt     = RES;
    ovf_nxt     = OVF;
    case (state)
      IDLE: begin
        if (st_rise) begin
          acc_nxt     = IN;
          rem_nxt     = CNT;
          mode_nxt    = MODE;
          ovf_int_nxt = 1'b0;
          rd_nxt      = 1'b0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (rem == '0) begin
          res_nxt   = acc;
          ovf_nxt   = ovf_int;
          rd_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          rem_nxt = rem - 1'b1;
          if (acc == MAXV) begin
            // The overflow flag is sticky, so repeated wraps still report
            // one overflow. Saturate mode keeps the accumulator pinned.
            ovf_int_nxt = 1'b1;
            if (!mode_q)
              acc_nxt = '0;
          end else begin
            acc_nxt = acc + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset aborts any running operation without publishing
  // a result. The start history tracks ST every cycle, including while busy.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      st_q    <= 1'b0;
      acc     <= '0;
      rem     <= '0;
      mode_q  <= 1'b0;
      ovf_int <= 1'b0;
      RD      <= 1'b1;
      RES     <= '0;
      OVF     <= 1'b0;
    end else begin
      state   <= state_nxt;
      st_q    <= ST;
      acc     <= acc_nxt;
      rem     <= rem_nxt;
      mode_q  <= mode_nxt;
      ovf_int <= ovf_int_nxt;
      RD      <= rd_nxt;
      RES     <= res_nxt;
      OVF     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_node_iter_succ.sv
// tb_node_iter_succ
// Scoreboard bench for node_iter_succ. The stimulus side pushes the expected
// result of every launched operation. The monitor pops an entry on each
// rising edge of RD and compares it against RES, OVF and the busy length.
module tb_node_iter_succ;

  localparam int W     = 16;
  localparam int CNT_W = 8;
  localparam longint MAXV = (64'd1 << W) - 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           busy;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ST;
  logic [W-1:0]     IN;
  logic [CNT_W-1:0] CNT;
  logic             MODE;
  logic             RD;
  logic [W-1:0]     RES;
  logic             OVF;

  exp_t         sb[$];
  int           checksTotal  = 0;
  int           checksPassed = 0;
  bit           monEnable    = 1'b0;
  bit           rstLowAtEdge = 1'b0;
  logic         prevRd       = 1'b1;
  int           busyCnt      = 0;
  logic [W-1:0] lastRes      = '0;

  node_iter_succ #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ST   (ST),
    .IN   (IN),
    .CNT  (CNT),
    .MODE (MODE),
    .RD   (RD),
    .RES  (RES),
    .OVF  (OVF)
  );

  // 10 ns clock period.
  always #5 CLK = ~CLK;

  // Record whether reset was applied at each edge. The monitor uses this to
  // tell an aborted operation apart from a real completion.
  always @(posedge CLK) rstLowAtEdge <= !RST;

  // Reference model. Computes the unsigned sum in wide arithmetic, then
  // either wraps it or clamps it to the top of the range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [CNT_W-1:0] n,
                                 input logic m);
    exp_t   e;
    longint sum;
    sum    = longint'(a) + longint'(n);
    e.ovf  = (sum > MAXV);
    e.res  = m ? (e.ovf ? W'(MAXV) : W'(sum)) : W'(sum % (MAXV + 1));
    e.busy = int'(n) + 1;
    return e;
  endfunction

  // Monitor. While busy, RES must hold the previous result. On each rising
  // edge of RD, the oldest expectation is popped and compared.
  always @(negedge CLK) begin
    if (monEnable) begin
      if (rstLowAtEdge) begin
        busyCnt = 0;
        lastRes = '0;
        prevRd  = RD;
      end else begin
        if (!RD) begin
          busyCnt++;
          checksTotal++;
          if (RES === lastRes) checksPassed++;
          else $display("[TB] FAIL busy_hold: RES=%h expected %h", RES, lastRes);
        end else if (!prevRd) begin
          checksTotal++;
          if (sb.size() == 0) begin
            $display("[TB] FAIL unexpected_completion: RES=%h OVF=%b with no operation pending",
                     RES, OVF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (RES === e.res && OVF === e.ovf && busyCnt == e.busy) checksPassed++;
            else $display("[TB] FAIL completion: RES=%h OVF=%b busy=%0d expected RES=%h OVF=%b busy=%0d",
                          RES, OVF, busyCnt, e.res, e.ovf, e.busy);
            lastRes = e.res;
          end
          busyCnt = 0;
        end
        prevRd = RD;
      end
    end
  end

  // Compare the visible outputs against explicit expected values.
  task automatic checkOutput(input string name, input logic expRd,
                             input logic [W-1:0] expRes, input logic expOvf);
    checksTotal++;
    if (RD === expRd && RES === expRes && OVF === expOvf) checksPassed++;
    else $display("[TB] FAIL %s: RD=%b RES=%h OVF=%b expected RD=%b RES=%h OVF=%b",
                  name, RD, RES, OVF, expRd, expRes, expOvf);
  endtask

  // Launch one operation and record its expected outcome. When holdSt is
  // set, ST is left high after the launch.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [CNT_W-1:0] n,
                               input logic m, input bit holdSt);
    @(negedge CLK);
    IN   = a;
    CNT  = n;
    MODE = m;
    ST   = 1'b1;
    sb.push_back(model(a, n, m));
    @(negedge CLK);
    if (!holdSt) ST = 1'b0;
  endtask

  // Wait, with a cycle budget, until the device is idle and every
  // expectation has been consumed.
  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (!(RD === 1'b1 && sb.size() == 0) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    checksTotal++;
    if (RD === 1'b1 && sb.size() == 0) checksPassed++;
    else $display("[TB] FAIL wait_idle: RD=%b pending=%0d after %0d cycles", RD, sb.size(), budget);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d",
             checksPassed, checksTotal);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST  = 1'b0;
    ST   = 1'b0;
    IN   = '0;
    CNT  = '0;
    MODE = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    monEnable = 1'b1;
    checkOutput("reset", 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("idle", 1'b1, 16'h0000, 1'b0);
    end

    applyStimulus(16'h0010, 8'd5, 1'b0, 1'b0);
    waitIdle(20);
    applyStimulus(16'hFFFE, 8'd4, 1'b0, 1'b0);
    waitIdle(20);
    applyStimulus(16'hFFFE, 8'd4, 1'b1, 1'b0);
    waitIdle(20);
    applyStimulus(16'h1234, 8'd0, 1'b0, 1'b0);
    waitIdle(20);

    // Retrigger attempts and operand changes mid-run must be ignored.
    applyStimulus(16'h0001, 8'd10, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    IN = 16'h00FF;
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    @(negedge CLK);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    waitIdle(30);

    // A start held high through completion must not relaunch.
    applyStimulus(16'h0020, 8'd3, 1'b0, 1'b1);
    waitIdle(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("st_held", 1'b1, 16'h0023, 1'b0);
    end
    ST = 1'b0;
    applyStimulus(16'h0100, 8'd1, 1'b0, 1'b0);
    waitIdle(20);

    // Reset in the middle of a run aborts the operation.
    applyStimulus(16'h0007, 8'd20, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    checkOutput("reset_midop", 1'b1, 16'h0000, 1'b0);
    RST = 1'b1;
    applyStimulus(16'h0007, 8'd2, 1'b0, 1'b0);
    waitIdle(20);

    // Randomised operations. Some operands sit near the top of the range,
    // and inputs are disturbed during the run.
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0]     a;
      logic [CNT_W-1:0] n;
      logic             m;
      a = ($urandom_range(0, 2) == 0) ? W'(MAXV - $urandom_range(0, 20)) : W'($urandom);
      n = CNT_W'($urandom_range(0, 40));
      m = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      applyStimulus(a, n, m, 1'b0);
      IN   = W'($urandom);
      CNT  = CNT_W'($urandom);
      MODE = 1'($urandom);
      waitIdle(int'(n) + 10);
    end

    repeat (3) @(negedge CLK);
    checksTotal++;
    if (sb.size() == 0) checksPassed++;
    else $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/node_iter_succ.md
Name: node_iter_succ

Overview:
- Parametrised successor node for the recursive-function tree: computes RES = IN + CNT by iterating the successor operation CNT times. It is the successor-primitive generalisation used wherever the tree needs "add constant/operand" without a combinational adder chain.
- It uses the node ST/RD start/ready handshake, so it drops into the same tree slots as other nodes.
- It adds configurable width, a run-time step count, wrap/saturate mode and an overflow flag.

Parameters:
- W, 16, data width of IN/RES.
- CNT_W, 8, width of the iteration-count operand CNT.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- ST  input  1  start request; rising edge (ST=1 now, 0 at the previous sampled edge) launches an operation.
- IN  input  W  base operand; sampled only at the launching edge.
- CNT  input  CNT_W  number of successor steps; sampled only at the launching edge.
- MODE  input  1  0 = wrap modulo 2^W, 1 = saturate at 2^W-1; sampled only at the launching edge.
- RD  output  1  ready; 1 = idle with result valid, 0 = busy.
- RES  output  W  result register.
- OVF  output  1  overflow flag for the last completed operation; valid when RD=1.

Behaviour:
- Reset (RST=0 at posedge): RD=1, RES=0, OVF=0, state IDLE, internal ST history=0, accumulator=0, remaining count=0. Reset overrides all other activity, including mid-operation: the operation aborts and no result is produced.
- ST history register updates on every non-reset posedge regardless of state. A ST held high across the end of an operation does not retrigger; ST must go low, then high again.
- State IDLE:
  - On a rising edge of ST: acc<=IN, rem<=CNT, mode<=MODE, ovf_int<=0, RD<=0, go RUN.
  - RES and OVF keep their previous values while busy.
- State RUN, one step per cycle:
  - If rem==0: RES<=acc, OVF<=ovf_int, RD<=1, go IDLE.
  - Else rem<=rem-1, and:
    - wrap mode: acc<=acc+1 modulo 2^W; if acc was 2^W-1, ovf_int<=1.
    - saturate mode: if acc==2^W-1, acc holds and ovf_int<=1; else acc<=acc+1.
- Latency: with the launching edge at posedge t, RD=0 from t through t+CNT, and RD=1 with the new RES/OVF at posedge t+CNT+1.
  - CNT=0: RES=IN, RD low for exactly 1 cycle.
- ST rising edges while in RUN are ignored (not queued). The history register still tracks them.
- IN, CNT and MODE changes during RUN have no effect.
- Arithmetic is unsigned. ovf_int is sticky within one operation: multiple wraps still give OVF=1.
- RES changes only at completion or reset.
- Maximum operation length is 2^CNT_W cycles. No internal timeout.

Test Plan:
- Reset/idle: hold RST=0 for 3 cycles, then release -> RD=1, RES=0, OVF=0; ST kept at 0 for 10 cycles -> no change.
- Basic: IN=0x0010, CNT=5, MODE=0, pulse ST -> RD=0 for exactly 6 cycles, then RD=1, RES=0x0015, OVF=0.
- Wrap: IN=0xFFFE, CNT=4, MODE=0 -> RES=0x0002, OVF=1 after 5 busy cycles.
- Saturate: IN=0xFFFE, CNT=4, MODE=1 -> RES=0xFFFF, OVF=1. Then IN=0x1234, CNT=0 -> RD low 1 cycle, RES=0x1234, OVF=0.
- Busy/retrigger: launch IN=1, CNT=10; toggle ST and change IN to 0x00FF mid-run -> RES=0x000B, no second operation. Hold ST high through completion -> no relaunch until ST goes low then high.
- Reset mid-operation: launch IN=7, CNT=20; assert RST=0 at busy cycle 5 -> next posedge RD=1, RES=0, OVF=0. Release reset, then relaunch IN=7, CNT=2 -> RES=9.
